data_mem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters:
  - the pipeline memory stage (pipe);
  - the serial program/data loader (ldr).
- Sits between those requesters and the data memory, and drives the memory's address, write data, enable and size inputs.
- Grants the pipe by priority. A bounded-starvation counter and a loader lock sequence the loader's accesses.
- Stalls the pipeline whenever the pipe loses arbitration, and steers the one-cycle-late read data back to the requester that issued the read.

---
 rtl/data_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data memory port between the pipeline memory
// stage (pipe) and the serial loader (ldr). The pipe has priority. The loader
// can lock the port across several accesses. Memory read data arrives one
// cycle after the access and is steered back to the requester that issued it.
// Optional build macro: DMARB_STARVE_EN adds a bounded-starvation counter.
// Once the loader has waited STARVE_MAX cycles, it is forced one grant.
module data_mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    // Pipeline memory stage
    input  logic          pipe_req_in,
    input  logic          pipe_we_in,
    input  logic [1:0]    pipe_size_in,
    input  logic [AW-1:0] pipe_addr_in,
    input  logic [DW-1:0] pipe_wdata_in,
    output logic          pipe_stall_out,
    output logic [DW-1:0] pipe_rdata_out,
    output logic          pipe_rvalid_out,
    // Serial loader
    input  logic          ldr_req_in,
    input  logic          ldr_lock_in,
    input  logic          ldr_we_in,
    input  logic [1:0]    ldr_size_in,
    input  logic [AW-1:0] ldr_addr_in,
    input  logic [DW-1:0] ldr_wdata_in,
    output logic          ldr_gnt_out,
    output logic [DW-1:0] ldr_rdata_out,
    output logic          ldr_rvalid_out,
    // Data memory
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_wdata_out,
    output logic          mem_we_out,
    output logic          mem_re_out,
    output logic [1:0]    mem_size_out,
    input  logic [DW-1:0] mem_rdata_in
);

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e        state_q, state_d;
    logic          pipe_grant, ldr_grant;
    logic          starved;
    logic          accept_read;
    logic          pending_q;
    logic          owner_q;  // 1 = loader owns the outstanding read
    logic [DW-1:0] pipe_rdata_q, ldr_rdata_q;

`ifdef DMARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starved = (starve_cnt_q == 4'(STARVE_MAX));

    // Count the cycles the loader waits. Clear the count on a grant or an idle request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ldr_req_in || ldr_grant) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_max;

    assign starved           = 1'b0;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    // Arbitration and lock sequencing. Grants are purely combinational.
    always_comb begin
        state_d    = state_q;
        pipe_grant = 1'b0;
        ldr_grant  = 1'b0;
        case (state_q)
            StArb: begin
                // A starved loader pre-empts the pipe for exactly one cycle.
                if (pipe_req_in && !(starved && ldr_req_in)) begin
                    pipe_grant = 1'b1;
                end else if (ldr_req_in) begin
                    ldr_grant = 1'b1;
                    if (ldr_lock_in) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                // The cycle that drops the lock is still the loader's.
                ldr_grant = ldr_req_in;
                if (!ldr_lock_in) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StArb;
        end else begin
            state_q <= state_d;
        end
    end

    assign pipe_stall_out = pipe_req_in & ~pipe_grant;
    assign ldr_gnt_out    = ldr_grant;

    // Drive the winner's payload to memory. Drive all zeros when nobody is granted.
    always_comb begin
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        mem_we_out    = 1'b0;
        mem_re_out    = 1'b0;
        mem_size_out  = 2'b00;
        if (pipe_grant) begin
            mem_addr_out  = pipe_addr_in;
            mem_wdata_out = pipe_wdata_in;
            mem_we_out    = pipe_we_in;
            mem_re_out    = ~pipe_we_in;
            mem_size_out  = pipe_size_in;
        end else if (ldr_grant) begin
            mem_addr_out  = ldr_addr_in;
            mem_wdata_out = ldr_wdata_in;
            mem_we_out    = ldr_we_in;
            mem_re_out    = ~ldr_we_in;
            mem_size_out  = ldr_size_in;
        end
    end

    assign accept_read = (pipe_grant & ~pipe_we_in) | (ldr_grant & ~ldr_we_in);

    // Track each accepted read and latch the returned data for its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= 1'b0;
            owner_q      <= 1'b0;
            pipe_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            pending_q <= accept_read;
            if (accept_read) begin
                owner_q <= ldr_grant;
            end
            if (pending_q && !owner_q) begin
                pipe_rdata_q <= mem_rdata_in;
            end
            if (pending_q && owner_q) begin
                ldr_rdata_q <= mem_rdata_in;
            end
        end
    end

    assign pipe_rvalid_out = pending_q & ~owner_q;
    assign ldr_rvalid_out  = pending_q & owner_q;

    // The returning owner sees memory data in the return cycle. The other side holds its data.
    assign pipe_rdata_out = pipe_rvalid_out ? mem_rdata_in : pipe_rdata_q;
    assign ldr_rdata_out  = ldr_rvalid_out  ? mem_rdata_in : ldr_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small synchronous memory model.
// Expectations follow the DMARB_STARVE_EN build setting.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_we;
    logic [1:0]  pipe_size;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        pipe_stall;
    logic [31:0] pipe_rdata;
    logic        pipe_rvalid;
    logic        ldr_req, ldr_lock, ldr_we;
    logic [1:0]  ldr_size;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_gnt;
    logic [31:0] ldr_rdata;
    logic        ldr_rvalid;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] tmem [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_req_in     (pipe_req),
        .pipe_we_in      (pipe_we),
        .pipe_size_in    (pipe_size),
        .pipe_addr_in    (pipe_addr),
        .pipe_wdata_in   (pipe_wdata),
        .pipe_stall_out  (pipe_stall),
        .pipe_rdata_out  (pipe_rdata),
        .pipe_rvalid_out (pipe_rvalid),
        .ldr_req_in      (ldr_req),
        .ldr_lock_in     (ldr_lock),
        .ldr_we_in       (ldr_we),
        .ldr_size_in     (ldr_size),
        .ldr_addr_in     (ldr_addr),
        .ldr_wdata_in    (ldr_wdata),
        .ldr_gnt_out     (ldr_gnt),
        .ldr_rdata_out   (ldr_rdata),
        .ldr_rvalid_out  (ldr_rvalid),
        .mem_addr_out    (mem_addr),
        .mem_wdata_out   (mem_wdata),
        .mem_we_out      (mem_we),
        .mem_re_out      (mem_re),
        .mem_size_out    (mem_size),
        .mem_rdata_in    (mem_rdata)
    );

    // Word-addressed memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr[9:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= tmem[mem_addr[9:2]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        pipe_req = 0; pipe_we = 0; pipe_size = 2'b10; pipe_addr = 0; pipe_wdata = 0;
        ldr_req = 0; ldr_lock = 0; ldr_we = 0; ldr_size = 2'b10; ldr_addr = 0; ldr_wdata = 0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_rd(input logic [31:0] a);
        pipe_req = 1; pipe_we = 0; pipe_addr = a;
    endtask

    task automatic ldr_acc(input logic we, input logic lock, input logic [31:0] a,
                           input logic [31:0] d);
        ldr_req = 1; ldr_we = we; ldr_lock = lock; ldr_addr = a; ldr_wdata = d;
    endtask

    logic exp_l;
    logic exp_stall_a;

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = 32'd0;
        tmem[64] = 32'hDEADBEEF;  // 0x100
        tmem[65] = 32'hCAFEF00D;  // 0x104
        idle();
        reset = 1;

        // Reset state
        to_neg();
        check_eq("rst_stall", pipe_stall, 0);
        check_eq("rst_gnt", ldr_gnt, 0);
        check_eq("rst_mem_re", mem_re, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_prvalid", pipe_rvalid, 0);
        check_eq("rst_lrvalid", ldr_rvalid, 0);
        check_eq("rst_prdata", pipe_rdata, 0);
        check_eq("rst_lrdata", ldr_rdata, 0);
        to_next();
        reset = 0;

        // Pipe-only read of 0x100
        pipe_rd(32'h100);
        to_neg();
        check_eq("p_stall", pipe_stall, 0);
        check_eq("p_mem_re", mem_re, 1);
        check_eq("p_mem_we", mem_we, 0);
        check_eq("p_mem_addr", mem_addr, 32'h100);
        check_eq("p_mem_size", mem_size, 2'b10);
        to_next();
        idle();
        to_neg();
        check_eq("p_rvalid", pipe_rvalid, 1);
        check_eq("p_rdata", pipe_rdata, 32'hDEADBEEF);
        check_eq("p_lrvalid", ldr_rvalid, 0);
        check_eq("p_idle_re", mem_re, 0);
        to_next();
        to_neg();
        check_eq("p_rvalid_drop", pipe_rvalid, 0);
        check_eq("p_rdata_hold", pipe_rdata, 32'hDEADBEEF);
        to_next();

        // Contention: both requesting continuously
        pipe_rd(32'h100);
        ldr_acc(0, 0, 32'h104, 0);
        for (int i = 0; i < 10; i++) begin
`ifdef DMARB_STARVE_EN
            exp_l = ((i % 5) == 4);
`else
            exp_l = 1'b0;
`endif
            to_neg();
            check_eq("c_gnt", ldr_gnt, exp_l);
            check_eq("c_stall", pipe_stall, exp_l);
            check_eq("c_addr", mem_addr, exp_l ? 32'h104 : 32'h100);
            to_next();
        end
        idle();
        to_next();

        // Lock: write 0x40, hold the port, then read back 0x40
`ifdef DMARB_STARVE_EN
        pipe_rd(32'h100);
        ldr_acc(1, 1, 32'h40, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            to_neg();
            check_eq("l_wait_gnt", ldr_gnt, 0);
            to_next();
        end
        exp_stall_a = 1'b1;
`else
        ldr_acc(1, 1, 32'h40, 32'h12345678);
        exp_stall_a = 1'b0;
`endif
        to_neg();
        check_eq("l_a_gnt", ldr_gnt, 1);
        check_eq("l_a_stall", pipe_stall, exp_stall_a);
        check_eq("l_a_we", mem_we, 1);
        check_eq("l_a_re", mem_re, 0);
        check_eq("l_a_addr", mem_addr, 32'h40);
        check_eq("l_a_wdata", mem_wdata, 32'h12345678);
        to_next();
        // Locked with no loader request: no access, the pipe is still stalled
        pipe_rd(32'h100);
        ldr_req = 0; ldr_lock = 1;
        to_neg();
        check_eq("l_hold_stall", pipe_stall, 1);
        check_eq("l_hold_re", mem_re, 0);
        check_eq("l_hold_we", mem_we, 0);
        check_eq("l_hold_gnt", ldr_gnt, 0);
        to_next();
        ldr_acc(0, 0, 32'h40, 0);
        to_neg();
        check_eq("l_b_gnt", ldr_gnt, 1);
        check_eq("l_b_stall", pipe_stall, 1);
        check_eq("l_b_re", mem_re, 1);
        check_eq("l_b_addr", mem_addr, 32'h40);
        to_next();
        ldr_req = 0;
        to_neg();
        check_eq("l_c_stall", pipe_stall, 0);
        check_eq("l_c_addr", mem_addr, 32'h100);
        check_eq("l_c_lrvalid", ldr_rvalid, 1);
        check_eq("l_c_lrdata", ldr_rdata, 32'h12345678);
        check_eq("l_c_prvalid", pipe_rvalid, 0);
        to_next();
        idle();
        to_neg();
        check_eq("l_d_prvalid", pipe_rvalid, 1);
        check_eq("l_d_prdata", pipe_rdata, 32'hDEADBEEF);
        check_eq("l_d_lrvalid", ldr_rvalid, 0);
        to_next();

        // Alternating owners: pipe read, then loader read in the next cycle
        pipe_rd(32'h104);
        to_next();
        idle();
        ldr_acc(0, 0, 32'h100, 0);
        to_neg();
        check_eq("a1_gnt", ldr_gnt, 1);
        check_eq("a1_prvalid", pipe_rvalid, 1);
        check_eq("a1_prdata", pipe_rdata, 32'hCAFEF00D);
        check_eq("a1_lrvalid", ldr_rvalid, 0);
        to_next();
        idle();
        to_neg();
        check_eq("a2_lrvalid", ldr_rvalid, 1);
        check_eq("a2_lrdata", ldr_rdata, 32'hDEADBEEF);
        check_eq("a2_prvalid", pipe_rvalid, 0);
        check_eq("a2_prdata_hold", pipe_rdata, 32'hCAFEF00D);
        to_next();

        // Reset asserted in the cycle after an accepted pipe read
        pipe_rd(32'h100);
        to_next();
        idle();
        reset = 1;
        to_neg();
        check_eq("r_prvalid", pipe_rvalid, 0);
        check_eq("r_lrvalid", ldr_rvalid, 0);
        check_eq("r_prdata", pipe_rdata, 0);
        check_eq("r_mem_re", mem_re, 0);
        check_eq("r_mem_addr", mem_addr, 0);
        to_next();
        reset = 0;
        // Back in the ARB state with the counter cleared
        pipe_rd(32'h100);
        ldr_acc(0, 0, 32'h104, 0);
        for (int i = 0; i < 5; i++) begin
`ifdef DMARB_STARVE_EN
            exp_l = (i == 4);
`else
            exp_l = 1'b0;
`endif
            to_neg();
            check_eq("r_arb_gnt", ldr_gnt, exp_l);
            check_eq("r_arb_stall", pipe_stall, exp_l);
            if (i == 0) check_eq("r_arb_prvalid", pipe_rvalid, 0);
            to_next();
        end
        idle();
        to_next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
